lf_adder32: RTL and testbench

Registered 32-bit Ladner-Fischer parallel-prefix adder. Operands are reduced to bitwise propagate/generate pairs, combined through a sparse prefix tree of black cells, and the sum and carry-out are captured in an output register. It serves as the fast add datapath element wherever a single-cycle 32-bit add with carry-out is needed.

---
 rtl/lfa_pkg.sv | 14 +
 rtl/lf_adder32_pg_black_cell.sv | 14 +
 rtl/lf_adder32.sv | 107 ++++++++++
 tb/tb_lf_adder32.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lfa_pkg.sv
// Shared width constants and payload types for the lf_adder32 datapath.
package lfa_pkg;

    localparam int unsigned LFA_W      = 32;
    localparam int unsigned LFA_LEVELS = 5;

    typedef logic [LFA_W-1:0] lfa_word_t;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage : lfa_pkg

// File: rtl/lf_adder32_pg_black_cell.sv
// Prefix black cell: merges a high propagate/generate span with the adjacent low span.
module pg_black_cell (
    input  logic p_h,
    input  logic g_h,
    input  logic p_l,
    input  logic g_l,
    output logic p_o,
    output logic g_o
);

    assign g_o = g_h | (p_h & g_l);
    assign p_o = p_h & p_l;

endmodule : pg_black_cell

// File: rtl/lf_adder32.sv
// Registered 32-bit Ladner-Fischer parallel-prefix adder with carry-out.
// Define LFA_INPUT_REG_EN to add an operand register stage (latency 2 instead of 1).
module lf_adder32
    import lfa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int unsigned TREE_D = LFA_LEVELS + 2;

    lfa_word_t s_a;
    lfa_word_t s_b;
    logic      s_valid;

`ifdef LFA_INPUT_REG_EN
    // Operand stage ahead of the prefix network.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a     <= '0;
            s_b     <= '0;
            s_valid <= 1'b0;
        end else begin
            s_a     <= a;
            s_b     <= b;
            s_valid <= in_valid;
        end
    end
`else
    assign s_a     = a;
    assign s_b     = b;
    assign s_valid = in_valid;
`endif

    // tree[0] is bitwise p/g, tree[1..5] the odd-bit LF levels, tree[6] the even fix-up.
    pg_t tree [TREE_D][LFA_W];

    lfa_word_t sum_c;
    logic      cout_c;

    for (genvar i = 0; i < LFA_W; i++) begin : g_lvl0
        assign tree[0][i].p = s_a[i] ^ s_b[i];
        assign tree[0][i].g = s_a[i] & s_b[i];
    end

    // Level k: odd bits in the upper half of each 2^(k+1) block take the lower block's last odd prefix.
    for (genvar k = 0; k < LFA_LEVELS; k++) begin : g_lvl
        for (genvar i = 0; i < LFA_W; i++) begin : g_bit
            if ((i % 2 == 1) && (((i >> k) & 1) == 1)) begin : g_cell
                localparam int J = ((i >> k) << k) - 1;
                pg_black_cell u_cell (
                    .p_h (tree[k][i].p),
                    .g_h (tree[k][i].g),
                    .p_l (tree[k][J].p),
                    .g_l (tree[k][J].g),
                    .p_o (tree[k+1][i].p),
                    .g_o (tree[k+1][i].g)
                );
            end else begin : g_pass
                assign tree[k+1][i] = tree[k][i];
            end
        end
    end

    for (genvar i = 0; i < LFA_W; i++) begin : g_even
        if ((i % 2 == 0) && (i >= 2)) begin : g_cell
            pg_black_cell u_cell (
                .p_h (tree[0][i].p),
                .g_h (tree[0][i].g),
                .p_l (tree[LFA_LEVELS][i-1].p),
                .g_l (tree[LFA_LEVELS][i-1].g),
                .p_o (tree[LFA_LEVELS+1][i].p),
                .g_o (tree[LFA_LEVELS+1][i].g)
            );
        end else begin : g_pass
            assign tree[LFA_LEVELS+1][i] = tree[LFA_LEVELS][i];
        end
    end

    assign sum_c[0] = tree[0][0].p;
    for (genvar i = 1; i < LFA_W; i++) begin : g_sum
        assign sum_c[i] = tree[0][i].p ^ tree[LFA_LEVELS+1][i-1].g;
    end
    assign cout_c = tree[LFA_LEVELS+1][LFA_W-1].g;

    // Result register: loads only on a valid stage, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= s_valid;
            if (s_valid) begin
                sum  <= sum_c;
                cout <= cout_c;
            end
        end
    end

endmodule : lf_adder32

// File: tb/tb_lf_adder32.sv
// Self-checking bench for lf_adder32: directed vectors, reset-in-flight and random pairs
// against an arithmetic model; honours LFA_INPUT_REG_EN for the expected latency.
module tb_lf_adder32;

`ifdef LFA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;

    int total = 0;
    int bad   = 0;

    // Each entry: {valid, 33-bit result}; front is the result visible after the next edge.
    logic [33:0] pend [$];
    logic [32:0] held;

    lf_adder32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < LAT - 1; i++) pend.push_back(34'd0);
        held = 33'd0;
    endtask

    // Drive one input beat, advance one edge, then check outputs against the model.
    task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [33:0] e;
        in_valid = v;
        a        = x;
        b        = y;
        pend.push_back({v, 33'(x) + 33'(y)});
        @(posedge clk);
        #1;
        e = pend.pop_front();
        if (e[33]) held = e[32:0];
        check({tag, "_valid"}, 33'(out_valid), 33'(e[33]));
        check({tag, "_result"}, {cout, sum}, held);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {out_valid, cout, sum}, 34'd0);
        rst_n = 1'b1;

        cycle(1'b1, 32'h3A6F36E3, 32'hF6AF8732, "vec_mixed");
        cycle(1'b1, 32'hFFFFFFFF, 32'h00000001, "vec_ripple");
        cycle(1'b1, 32'h7FFFFFFF, 32'h00000001, "vec_msb");
        cycle(1'b1, 32'h00000000, 32'h00000000, "vec_zero");
        cycle(1'b1, 32'hAAAAAAAA, 32'h55555555, "vec_alt");
        cycle(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, "vec_allones");
        for (int i = 0; i < LAT; i++) cycle(1'b0, 32'h0, 32'h0, "drain");
        check("const_mixed_ripple_seen", {cout, sum}, 33'h1FFFFFFFE);

        cycle(1'b1, 32'h12345678, 32'h87654321, "b2b_0");
        cycle(1'b1, 32'h80000000, 32'h80000000, "b2b_1");
        cycle(1'b1, 32'h0000FFFF, 32'h00000001, "b2b_2");
        cycle(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "gap");
        cycle(1'b1, 32'h00010000, 32'hFFFF0000, "after_gap");
        for (int i = 0; i < LAT + 1; i++) cycle(1'b0, 32'h1, 32'h1, "hold");

        // Asynchronous reset mid-stream, between edges, with a beat in flight.
        cycle(1'b1, 32'hCAFEF00D, 32'h13572468, "pre_rst_0");
        in_valid = 1'b1;
        a        = 32'hFFFF0000;
        b        = 32'h0001FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_now", {out_valid, cout, sum}, 34'd0);
        @(posedge clk);
        #1;
        check("rst_held", {out_valid, cout, sum}, 34'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < LAT + 1; i++) cycle(1'b0, 32'hFFFFFFFF, 32'h1, "post_rst_idle");
        cycle(1'b1, 32'h00000005, 32'h00000007, "post_rst_first");
        for (int i = 0; i < LAT; i++) cycle(1'b0, 32'h0, 32'h0, "post_rst_drain");

        for (int n = 0; n < 10000; n++) begin
            logic        v;
            logic [31:0] x;
            logic [31:0] y;
            v = ($urandom_range(0, 9) != 0);
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: y = ~x;
                1: y = 32'(0) - x;
                default: ;
            endcase
            cycle(v, x, y, "rand");
        end
        for (int i = 0; i < LAT; i++) cycle(1'b0, 32'h0, 32'h0, "final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lf_adder32
